// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package div16_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div16_seq_div_step.sv
// One restoring-division iteration: trial subtract the divisor from the shifted
// partial remainder and keep the difference only when no borrow occurs.
module div_step
  import div16_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // The shifted remainder is below 2*divisor, so the kept result always fits WIDTH bits
  // and the top bit of the WIDTH+1 bit difference is the borrow.
  always_comb begin
    diff    = rem_in - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
  end

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned divider: one quotient bit per clock, WIDTH iterations per divide,
// zero divisor short-circuits straight to the result state.
module div16_seq
  import div16_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             accept_run;
  logic             accept_zero;
  logic             last_iter;

  // dvd_shift feeds dividend bits out of its top while quotient bits enter at the bottom,
  // so after WIDTH shifts it holds the quotient.
  assign rem_shifted = {prem, dvd_shift[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_shifted),
    .divisor (dvs_reg),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Next-state decode: start is only honoured outside RUN, zero divisor skips RUN.
  always_comb begin
    state_next  = state;
    accept_run  = 1'b0;
    accept_zero = 1'b0;
    last_iter   = (count == CW'(WIDTH - 1));
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          if (divisor == '0) begin
            accept_zero = 1'b1;
            state_next  = DONE;
          end else begin
            accept_run = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch operands on accept, iterate in RUN, publish results only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      dvd_shift   <= '0;
      dvs_reg     <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_run) begin
      count     <= '0;
      dvd_shift <= dividend;
      dvs_reg   <= divisor;
      prem      <= '0;
    end else if (accept_zero) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (state == RUN) begin
      prem      <= rem_next;
      dvd_shift <= {dvd_shift[WIDTH-2:0], q_bit};
      count     <= count + CW'(1);
      if (last_iter) begin
        quotient    <= {dvd_shift[WIDTH-2:0], q_bit};
        remainder   <= rem_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
